fft16_mem_ctrl: RTL and testbench

Sequencer for the 16-entry x 32-bit dual-write/dual-read FFT working memory (one word = {re[15:0], im[15:0]}).
- Loads 16 input samples in bit-reversed order.
- Runs 4 in-place radix-2 DIT stages of 8 butterflies each through an external fixed-latency butterfly unit.
- Streams the 16 results out in natural order.
- Drives every memory address and enable, the write-data select, and the twiddle index.

---
 rtl/fft16_mem_ctrl_pkg.sv | 21 ++
 rtl/fft16_mem_ctrl_if.sv | 41 ++++
 rtl/fft16_wb_delay.sv | 45 ++++
 rtl/fft16_mem_ctrl.sv | 146 ++++++++++++++
 tb/tb_fft16_mem_ctrl.sv | 391 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fft16_mem_ctrl_pkg.sv
// Shared constants, state encoding and address helpers for the 16-point FFT
// memory sequencer.
package fft16_mem_ctrl_pkg;

  localparam int unsigned FFT_N     = 16;
  localparam int unsigned FFT_LOG2N = 4;
  localparam int unsigned DATA_W    = 32;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_CALC   = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_UNLOAD = 3'd4
  } state_t;

  function automatic logic [FFT_LOG2N-1:0] bitrev4(input logic [FFT_LOG2N-1:0] v);
    return {v[0], v[1], v[2], v[3]};
  endfunction

endpackage

// File: rtl/fft16_mem_ctrl_if.sv
// Handshake, memory-port and butterfly-control bundle between the sequencer
// (master) and its memory/datapath environment (slave).
interface fft16_mem_ctrl_if;
  import fft16_mem_ctrl_pkg::*;

  logic                 start;
  logic                 busy;
  logic                 done;
  logic                 in_valid;
  logic                 in_ready;
  logic                 out_valid;
  logic                 out_ready;
  logic [3:0]           out_idx;
  logic                 wr_sel;
  logic [3:0]           write_addr_1;
  logic                 write_en_1;
  logic [3:0]           write_addr_2;
  logic                 write_en_2;
  logic [3:0]           read_addr_1;
  logic [3:0]           read_addr_2;
  logic                 bf_valid;
  logic [2:0]           tw_idx;
  logic [1:0]           stage;
  // Memory read port 1 as seen by the environment; the sequencer never uses it.
  logic [DATA_W-1:0]    read_data_1;

  modport master (
    input  start, in_valid, out_ready,
    output busy, done, in_ready, out_valid, out_idx, wr_sel,
           write_addr_1, write_en_1, write_addr_2, write_en_2,
           read_addr_1, read_addr_2, bf_valid, tw_idx, stage
  );

  modport slave (
    output start, in_valid, out_ready, read_data_1,
    input  busy, done, in_ready, out_valid, out_idx, wr_sel,
           write_addr_1, write_en_1, write_addr_2, write_en_2,
           read_addr_1, read_addr_2, bf_valid, tw_idx, stage
  );

endinterface

// File: rtl/fft16_wb_delay.sv
// BF_LAT-deep {valid, addr_a, addr_b} pipe that aligns write-back addresses
// with the butterfly unit's results.
module fft16_wb_delay
  import fft16_mem_ctrl_pkg::*;
#(
  parameter int unsigned BF_LAT = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_valid,
  input  logic [FFT_LOG2N-1:0] i_addr_a,
  input  logic [FFT_LOG2N-1:0] i_addr_b,
  output logic                 o_valid,
  output logic [FFT_LOG2N-1:0] o_addr_a,
  output logic [FFT_LOG2N-1:0] o_addr_b
);

  logic [BF_LAT-1:0]    r_valid;
  logic [FFT_LOG2N-1:0] r_addr_a [BF_LAT];
  logic [FFT_LOG2N-1:0] r_addr_b [BF_LAT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      for (int unsigned i = 0; i < BF_LAT; i++) begin
        r_addr_a[i] <= '0;
        r_addr_b[i] <= '0;
      end
    end else begin
      r_valid[0]  <= i_valid;
      r_addr_a[0] <= i_addr_a;
      r_addr_b[0] <= i_addr_b;
      for (int unsigned i = 1; i < BF_LAT; i++) begin
        r_valid[i]  <= r_valid[i-1];
        r_addr_a[i] <= r_addr_a[i-1];
        r_addr_b[i] <= r_addr_b[i-1];
      end
    end
  end

  assign o_valid  = r_valid[BF_LAT-1];
  assign o_addr_a = r_addr_a[BF_LAT-1];
  assign o_addr_b = r_addr_b[BF_LAT-1];

endmodule

// File: rtl/fft16_mem_ctrl.sv
// 16-point radix-2 DIT FFT memory sequencer: bit-reversed load, 4 in-place
// butterfly stages through an external BF_LAT-cycle unit, natural-order unload.
module fft16_mem_ctrl
  import fft16_mem_ctrl_pkg::*;
#(
  parameter int unsigned BF_LAT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  fft16_mem_ctrl_if.master bus
);

  localparam logic [3:0] LAST_IDX   = 4'(FFT_N - 1);
  localparam logic [3:0] LAST_K     = 4'(FFT_N / 2 - 1);
  localparam logic [3:0] DRAIN_LAST = 4'(BF_LAT - 1);
  localparam logic [1:0] LAST_STAGE = 2'(FFT_LOG2N - 1);

  state_t     r_state, w_state_nx;
  logic [3:0] r_cnt, w_cnt_nx;
  logic [1:0] r_stage, w_stage_nx;
  logic       r_done, w_done_nx;

  logic [3:0] w_span, w_pos, w_grp, w_a, w_b;
  logic       w_issue;
  logic       w_wb_valid;
  logic [3:0] w_wb_a, w_wb_b;

  // a = grp*2*span + pos; pos < span so the sum reduces to an OR.
  assign w_span  = 4'd1 << r_stage;
  assign w_pos   = {1'b0, r_cnt[2:0]} & (w_span - 4'd1);
  assign w_grp   = {1'b0, r_cnt[2:0]} >> r_stage;
  assign w_a     = (w_grp << ({1'b0, r_stage} + 3'd1)) | w_pos;
  assign w_b     = w_a + w_span;
  assign w_issue = (r_state == ST_CALC);

  fft16_wb_delay #(.BF_LAT(BF_LAT)) u_wb_delay (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_valid  (w_issue),
    .i_addr_a (w_a),
    .i_addr_b (w_b),
    .o_valid  (w_wb_valid),
    .o_addr_a (w_wb_a),
    .o_addr_b (w_wb_b)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_stage <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_stage <= w_stage_nx;
      r_done  <= w_done_nx;
    end
  end

  always_comb begin
    w_state_nx       = r_state;
    w_cnt_nx         = r_cnt;
    w_stage_nx       = r_stage;
    w_done_nx        = 1'b0;
    bus.busy         = (r_state != ST_IDLE);
    bus.done         = r_done;
    bus.in_ready     = 1'b0;
    bus.out_valid    = 1'b0;
    bus.out_idx      = '0;
    bus.bf_valid     = 1'b0;
    bus.read_addr_1  = '0;
    bus.read_addr_2  = '0;
    bus.tw_idx       = '0;
    bus.stage        = r_stage;
    bus.wr_sel       = w_wb_valid;
    bus.write_en_1   = w_wb_valid;
    bus.write_en_2   = w_wb_valid;
    bus.write_addr_1 = w_wb_valid ? w_wb_a : '0;
    bus.write_addr_2 = w_wb_valid ? w_wb_b : '0;

    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_state_nx = ST_LOAD;
          w_cnt_nx   = '0;
          w_stage_nx = '0;
        end
      end
      ST_LOAD: begin
        bus.in_ready = 1'b1;
        bus.wr_sel   = 1'b0;
        if (bus.in_valid) begin
          bus.write_en_1   = 1'b1;
          bus.write_addr_1 = bitrev4(r_cnt);
          w_cnt_nx         = r_cnt + 4'd1;
          if (r_cnt == LAST_IDX) begin
            w_state_nx = ST_CALC;
            w_cnt_nx   = '0;
          end
        end
      end
      ST_CALC: begin
        bus.bf_valid    = 1'b1;
        bus.read_addr_1 = w_a;
        bus.read_addr_2 = w_b;
        bus.tw_idx      = w_pos[2:0] << (2'd3 - r_stage);
        w_cnt_nx        = r_cnt + 4'd1;
        if (r_cnt == LAST_K) begin
          w_state_nx = ST_DRAIN;
          w_cnt_nx   = '0;
        end
      end
      ST_DRAIN: begin
        // Hold off the next stage until its operands have been written back.
        if (r_cnt == DRAIN_LAST) begin
          w_cnt_nx = '0;
          if (r_stage != LAST_STAGE) begin
            w_stage_nx = r_stage + 2'd1;
            w_state_nx = ST_CALC;
          end else begin
            w_state_nx = ST_UNLOAD;
          end
        end else begin
          w_cnt_nx = r_cnt + 4'd1;
        end
      end
      ST_UNLOAD: begin
        bus.out_valid   = 1'b1;
        bus.out_idx     = r_cnt;
        bus.read_addr_1 = r_cnt;
        if (bus.out_ready) begin
          w_cnt_nx = r_cnt + 4'd1;
          if (r_cnt == LAST_IDX) begin
            w_state_nx = ST_IDLE;
            w_cnt_nx   = '0;
            w_stage_nx = '0;
            w_done_nx  = 1'b1;
          end
        end
      end
      default: w_state_nx = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_fft16_mem_ctrl.sv
// Directed bench for fft16_mem_ctrl: BF_LAT=2 instance with a memory and
// butterfly model, plus a BF_LAT=4 instance for write-back timing.
module tb_fft16_mem_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  int unsigned errors = 0;
  int unsigned checks = 0;

  always #5 clk = ~clk;

  fft16_mem_ctrl_if b2 ();
  fft16_mem_ctrl_if b4 ();

  fft16_mem_ctrl #(.BF_LAT(2)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(b2));
  fft16_mem_ctrl #(.BF_LAT(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(b4));

  assign b4.in_valid    = 1'b1;
  assign b4.out_ready   = 1'b1;
  assign b4.read_data_1 = '0;

  // Memory and butterfly model for the BF_LAT=2 instance.
  logic [31:0] mem [16];
  logic [31:0] in_sample;
  logic [31:0] rd2;
  logic [63:0] bf_p0, bf_p1;

  assign b2.read_data_1 = mem[b2.read_addr_1];
  assign rd2            = mem[b2.read_addr_2];

  function automatic logic [63:0] bfly(input logic [31:0] x, input logic [31:0] y,
                                       input logic [2:0] k);
    int c, s, xr, xi, yr, yi, tr, ti;
    case (k)
      3'd0: begin c =  32767; s =     0; end
      3'd1: begin c =  30274; s = 12540; end
      3'd2: begin c =  23170; s = 23170; end
      3'd3: begin c =  12540; s = 30274; end
      3'd4: begin c =      0; s = 32767; end
      3'd5: begin c = -12540; s = 30274; end
      3'd6: begin c = -23170; s = 23170; end
      default: begin c = -30274; s = 12540; end
    endcase
    xr = int'($signed(x[31:16])); xi = int'($signed(x[15:0]));
    yr = int'($signed(y[31:16])); yi = int'($signed(y[15:0]));
    tr = (yr * c + yi * s) >>> 15;
    ti = (yi * c - yr * s) >>> 15;
    return {16'((xr + tr) >>> 1), 16'((xi + ti) >>> 1),
            16'((xr - tr) >>> 1), 16'((xi - ti) >>> 1)};
  endfunction

  always_ff @(posedge clk) begin
    bf_p0 <= bfly(b2.read_data_1, rd2, b2.tw_idx);
    bf_p1 <= bf_p0;
    if (b2.write_en_1) mem[b2.write_addr_1] <= b2.wr_sel ? bf_p1[63:32] : in_sample;
    if (b2.write_en_2) mem[b2.write_addr_2] <= bf_p1[31:0];
  end

  // All outputs packed, for reset-value comparisons.
  logic [32:0] b2_all, b4_all;
  assign b2_all = {b2.busy, b2.done, b2.in_ready, b2.out_valid, b2.wr_sel, b2.write_en_1,
                   b2.write_en_2, b2.bf_valid, b2.write_addr_1, b2.write_addr_2,
                   b2.read_addr_1, b2.read_addr_2, b2.tw_idx, b2.stage, b2.out_idx};
  assign b4_all = {b4.busy, b4.done, b4.in_ready, b4.out_valid, b4.wr_sel, b4.write_en_1,
                   b4.write_en_2, b4.bf_valid, b4.write_addr_1, b4.write_addr_2,
                   b4.read_addr_1, b4.read_addr_2, b4.tw_idx, b4.stage, b4.out_idx};

  // Observation mux for the write-back timing scenario.
  logic sel4;
  logic m_bfv, m_we1, m_we2, m_wrsel, m_inr, m_done;
  logic [3:0] m_ra1, m_ra2, m_wa1, m_wa2;
  logic [1:0] m_stage;
  assign m_bfv   = sel4 ? b4.bf_valid     : b2.bf_valid;
  assign m_we1   = sel4 ? b4.write_en_1   : b2.write_en_1;
  assign m_we2   = sel4 ? b4.write_en_2   : b2.write_en_2;
  assign m_wrsel = sel4 ? b4.wr_sel       : b2.wr_sel;
  assign m_inr   = sel4 ? b4.in_ready     : b2.in_ready;
  assign m_done  = sel4 ? b4.done         : b2.done;
  assign m_ra1   = sel4 ? b4.read_addr_1  : b2.read_addr_1;
  assign m_ra2   = sel4 ? b4.read_addr_2  : b2.read_addr_2;
  assign m_wa1   = sel4 ? b4.write_addr_1 : b2.write_addr_1;
  assign m_wa2   = sel4 ? b4.write_addr_2 : b2.write_addr_2;
  assign m_stage = sel4 ? b4.stage        : b2.stage;

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (b2_all !== '0) begin
      errors++; $display("FAIL reset_lat2: outputs=%h required 0", b2_all);
    end
    checks++;
    if (b4_all !== '0) begin
      errors++; $display("FAIL reset_lat4: outputs=%h required 0", b4_all);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_load();
    logic [3:0] brtab [16] = '{4'd0, 4'd8, 4'd4, 4'd12, 4'd2, 4'd10, 4'd6, 4'd14,
                               4'd1, 4'd9, 4'd5, 4'd13, 4'd3, 4'd11, 4'd7, 4'd15};
    int unsigned acc = 0, we_cnt = 0, cyc = 0;
    @(negedge clk);
    b2.start = 1'b1;
    @(negedge clk);
    b2.start = 1'b0;
    while (acc < 16 && cyc < 100) begin
      b2.in_valid = (cyc % 3 != 2);
      in_sample   = (acc == 0) ? 32'h7FFF_0000 : 32'h0;
      #1;
      if (b2.write_en_1) we_cnt++;
      checks++;
      if (b2.in_ready !== 1'b1 || b2.busy !== 1'b1) begin
        errors++; $display("FAIL load_ready: in_ready=%b busy=%b required 1 1", b2.in_ready, b2.busy);
      end
      if (b2.in_valid) begin
        checks++;
        if (b2.write_en_1 !== 1'b1 || b2.write_addr_1 !== brtab[acc] || b2.wr_sel !== 1'b0) begin
          errors++;
          $display("FAIL load_addr: sample %0d we=%b addr=%0d sel=%b required 1 %0d 0",
                   acc, b2.write_en_1, b2.write_addr_1, b2.wr_sel, brtab[acc]);
        end
        acc++;
      end else begin
        checks++;
        if (b2.write_en_1 !== 1'b0) begin
          errors++; $display("FAIL load_gap: write_en_1=%b required 0", b2.write_en_1);
        end
      end
      cyc++;
      if (acc < 16) @(negedge clk);
    end
    checks++;
    if (we_cnt != 16) begin
      errors++; $display("FAIL load_count: write pulses=%0d required 16", we_cnt);
    end
  endtask

  task automatic test_addressing();
    logic [3:0] ga [32] = '{0,2,4,6,8,10,12,14, 0,1,4,5,8,9,12,13,
                            0,1,2,3,8,9,10,11, 0,1,2,3,4,5,6,7};
    logic [3:0] gb [32] = '{1,3,5,7,9,11,13,15, 2,3,6,7,10,11,14,15,
                            4,5,6,7,12,13,14,15, 8,9,10,11,12,13,14,15};
    logic [2:0] gt [32] = '{0,0,0,0,0,0,0,0, 0,4,0,4,0,4,0,4,
                            0,2,4,6,0,2,4,6, 0,1,2,3,4,5,6,7};
    int unsigned issues = 0, cyc = 0;
    while (issues < 32 && cyc < 200) begin
      @(negedge clk);
      b2.start = (issues == 11);
      #1;
      if (cyc == 0) begin
        checks++;
        if (b2.in_ready !== 1'b0 || b2.write_en_1 !== 1'b0 || b2.bf_valid !== 1'b1) begin
          errors++;
          $display("FAIL calc_entry: in_ready=%b we1=%b bf_valid=%b required 0 0 1",
                   b2.in_ready, b2.write_en_1, b2.bf_valid);
        end
      end
      checks++;
      if (b2.busy !== 1'b1) begin
        errors++; $display("FAIL calc_busy: busy=%b required 1", b2.busy);
      end
      if (b2.bf_valid) begin
        checks++;
        if (b2.read_addr_1 !== ga[issues] || b2.read_addr_2 !== gb[issues] ||
            b2.tw_idx !== gt[issues] || b2.stage !== 2'(issues / 8)) begin
          errors++;
          $display("FAIL calc_addr: issue %0d rd=%0d/%0d tw=%0d stage=%0d required %0d/%0d tw=%0d stage=%0d",
                   issues, b2.read_addr_1, b2.read_addr_2, b2.tw_idx, b2.stage,
                   ga[issues], gb[issues], gt[issues], issues / 8);
        end
        issues++;
      end
      cyc++;
    end
    b2.start = 1'b0;
    checks++;
    if (issues != 32) begin
      errors++; $display("FAIL calc_issues: issued=%0d required 32", issues);
    end
  endtask

  task automatic test_unload_backpressure();
    logic [3:0] pat = 4'b1001;
    int unsigned exp_idx = 0, cyc = 0;
    b2.in_valid = 1'b0;
    while (exp_idx < 16 && cyc < 200) begin
      @(negedge clk);
      b2.out_ready = pat[cyc % 4];
      #1;
      checks++;
      if (b2.done !== 1'b0) begin
        errors++; $display("FAIL unload_early_done: done=%b required 0", b2.done);
      end
      if (b2.out_valid) begin
        checks++;
        if (b2.out_idx !== 4'(exp_idx) || b2.read_addr_1 !== 4'(exp_idx)) begin
          errors++;
          $display("FAIL unload_idx: out_idx=%0d read_addr_1=%0d required %0d",
                   b2.out_idx, b2.read_addr_1, exp_idx);
        end
        checks++;
        if (b2.read_data_1 !== 32'h07FF_0000) begin
          errors++;
          $display("FAIL unload_data: idx %0d word=%h required 07ff0000", exp_idx, b2.read_data_1);
        end
        if (b2.out_ready) exp_idx++;
      end
      cyc++;
    end
    checks++;
    if (exp_idx != 16) begin
      errors++; $display("FAIL unload_count: accepted=%0d required 16", exp_idx);
    end
    @(negedge clk);
    #1;
    checks++;
    if (b2.done !== 1'b1 || b2.busy !== 1'b0 || b2.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL unload_done: done=%b busy=%b out_valid=%b required 1 0 0",
               b2.done, b2.busy, b2.out_valid);
    end
    @(negedge clk);
    #1;
    checks++;
    if (b2.done !== 1'b0) begin
      errors++; $display("FAIL done_pulse: done=%b required 0", b2.done);
    end
    b2.out_ready = 1'b1;
  endtask

  task automatic test_wb_timing(input bit use4, input int unsigned lat);
    int unsigned iss_c [$];
    logic [3:0]  iss_a [$];
    logic [3:0]  iss_b [$];
    int unsigned cyc = 0, first_c = 0, last_wr_c = 0, writes = 0, issues = 0, ic;
    logic [3:0]  ea, eb;
    logic [1:0]  prev_stage = '0;
    bit          got_done = 1'b0;
    sel4 = use4;
    b2.in_valid  = 1'b1;
    b2.out_ready = 1'b1;
    @(negedge clk);
    if (use4) b4.start = 1'b1; else b2.start = 1'b1;
    while (!got_done && cyc < 400) begin
      @(negedge clk);
      b2.start = 1'b0;
      b4.start = 1'b0;
      #1;
      cyc++;
      if (m_bfv) begin
        if (issues == 0) first_c = cyc;
        else if (m_stage != prev_stage) begin
          checks++;
          if (iss_c.size() != 0 || cyc <= last_wr_c) begin
            errors++;
            $display("FAIL wb_stage_order lat%0d: stage %0d issued with %0d writes pending",
                     lat, m_stage, iss_c.size());
          end
        end
        prev_stage = m_stage;
        iss_c.push_back(cyc);
        iss_a.push_back(m_ra1);
        iss_b.push_back(m_ra2);
        issues++;
      end
      if (!m_inr && (m_we1 || m_we2)) begin
        checks++;
        if (iss_c.size() == 0) begin
          errors++; $display("FAIL wb_orphan lat%0d: write with no pending issue", lat);
        end else begin
          ic = iss_c.pop_front();
          ea = iss_a.pop_front();
          eb = iss_b.pop_front();
          if (cyc - ic != lat) begin
            errors++; $display("FAIL wb_latency lat%0d: delay=%0d required %0d", lat, cyc - ic, lat);
          end
          checks++;
          if (m_we1 !== 1'b1 || m_we2 !== 1'b1 || m_wa1 !== ea || m_wa2 !== eb || m_wrsel !== 1'b1) begin
            errors++;
            $display("FAIL wb_addr lat%0d: we=%b%b wa=%0d/%0d sel=%b required 11 %0d/%0d 1",
                     lat, m_we1, m_we2, m_wa1, m_wa2, m_wrsel, ea, eb);
          end
        end
        writes++;
        last_wr_c = cyc;
      end
      if (m_done) got_done = 1'b1;
    end
    checks++;
    if (issues != 32 || writes != 32 || !got_done) begin
      errors++;
      $display("FAIL wb_totals lat%0d: issues=%0d writes=%0d done=%b required 32 32 1",
               lat, issues, writes, got_done);
    end
    checks++;
    if (last_wr_c - first_c != 4 * (8 + lat) - 1) begin
      errors++;
      $display("FAIL wb_phase_len lat%0d: span=%0d required %0d",
               lat, last_wr_c - first_c + 1, 4 * (8 + lat));
    end
    sel4 = 1'b0;
  endtask

  task automatic test_reset_mid_calc();
    int unsigned cyc = 0;
    b2.in_valid = 1'b1;
    @(negedge clk);
    b2.start = 1'b1;
    while (cyc < 100) begin
      @(negedge clk);
      b2.start = 1'b0;
      #1;
      cyc++;
      if (b2.bf_valid) break;
    end
    checks++;
    if (b2.bf_valid !== 1'b1) begin
      errors++; $display("FAIL rst_reach_calc: bf_valid=%b required 1", b2.bf_valid);
    end
    repeat (3) @(negedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (b2_all !== '0) begin
      errors++; $display("FAIL rst_async: outputs=%h required 0", b2_all);
    end
    repeat (3) begin
      @(negedge clk);
      #1;
      checks++;
      if (b2_all !== '0) begin
        errors++; $display("FAIL rst_hold: outputs=%h required 0", b2_all);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    b2.in_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      #1;
      checks++;
      if (b2.busy !== 1'b0 || b2.write_en_1 !== 1'b0 || b2.write_en_2 !== 1'b0) begin
        errors++;
        $display("FAIL rst_idle: busy=%b we=%b%b required 0 00", b2.busy, b2.write_en_1, b2.write_en_2);
      end
    end
    @(negedge clk);
    b2.start = 1'b1;
    @(negedge clk);
    b2.start    = 1'b0;
    b2.in_valid = 1'b1;
    #1;
    checks++;
    if (b2.in_ready !== 1'b1 || b2.write_en_1 !== 1'b1 || b2.write_addr_1 !== 4'd0 || b2.stage !== 2'd0) begin
      errors++;
      $display("FAIL rst_reload0: in_ready=%b we1=%b addr=%0d stage=%0d required 1 1 0 0",
               b2.in_ready, b2.write_en_1, b2.write_addr_1, b2.stage);
    end
    @(negedge clk);
    #1;
    checks++;
    if (b2.write_en_1 !== 1'b1 || b2.write_addr_1 !== 4'd8) begin
      errors++;
      $display("FAIL rst_reload1: we1=%b addr=%0d required 1 8", b2.write_en_1, b2.write_addr_1);
    end
    b2.in_valid = 1'b0;
  endtask

  initial begin
    sel4         = 1'b0;
    b2.start     = 1'b0;
    b2.in_valid  = 1'b0;
    b2.out_ready = 1'b0;
    b4.start     = 1'b0;
    in_sample    = '0;
    test_reset();
    test_load();
    test_addressing();
    test_unload_backpressure();
    test_wb_timing(1'b0, 2);
    test_wb_timing(1'b1, 4);
    test_reset_mid_calc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
